// File: rtl/fpu_pkg.sv
// Shared FPU opcode map and writeback routing helpers.
package fpu_pkg;

    localparam int unsigned FOP_ADD_D  = 0;
    localparam int unsigned FOP_SUB_D  = 1;
    localparam int unsigned FOP_MUL_D  = 2;
    localparam int unsigned FOP_DIV_D  = 3;
    localparam int unsigned FOP_SQRT_D = 4;
    localparam int unsigned FOP_CVT_L_D = 5;
    localparam int unsigned FOP_CVT_D_L = 6;
    localparam int unsigned FOP_MV_X_D = 7;
    localparam int unsigned FOP_MV_D_X = 8;
    localparam int unsigned FOP_ADD_S  = 9;
    localparam int unsigned FOP_SUB_S  = 10;
    localparam int unsigned FOP_MUL_S  = 11;
    localparam int unsigned FOP_DIV_S  = 12;
    localparam int unsigned FOP_SQRT_S = 13;

    typedef enum logic {ROUTE_FP = 1'b0, ROUTE_INT = 1'b1} route_e;

    function automatic logic op_is_legal(input int unsigned op);
        return op <= FOP_SQRT_S;
    endfunction

    function automatic route_e op_route(input int unsigned op);
        return (op == FOP_CVT_L_D || op == FOP_MV_X_D) ? ROUTE_INT : ROUTE_FP;
    endfunction

    function automatic logic op_is_single(input int unsigned op);
        return op >= FOP_ADD_S && op <= FOP_SQRT_S;
    endfunction

endpackage

// File: rtl/fpu_wb_fifo.sv
// Generic power-of-two synchronous FIFO with occupancy and a per-entry view.
module fpu_wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [WIDTH-1:0]              wdata,
    input  logic                          pop,
    output logic [WIDTH-1:0]              rdata,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(DEPTH):0]        count,
    output logic [DEPTH-1:0]              ent_vld,
    output logic [DEPTH-1:0][WIDTH-1:0]   ent_data
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic                        do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata    = mem[rd_ptr];
    assign ent_data = mem;

    for (genvar i = 0; i < DEPTH; i++) begin : g_vld
        logic [AW-1:0] off;
        assign off        = AW'(i) - rd_ptr;
        assign ent_vld[i] = ({1'b0, off} < count);
    end

endmodule

// File: rtl/fpu_writeback.sv
// FPU result writeback: buffers results, routes to FP/INT register files,
// NaN-boxes singles, and tracks pending FP destinations.
module fpu_writeback
    import fpu_pkg::*;
#(
    parameter int BUS_WIDTH = 64,
    parameter int OP_LEN    = 5,
    parameter int REG_ADDR  = 5,
    parameter int DEPTH     = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BUS_WIDTH-1:0]    in_result,
    input  logic [OP_LEN-1:0]       in_op,
    input  logic [REG_ADDR-1:0]     in_rd,
    output logic                    fp_we,
    output logic [REG_ADDR-1:0]     fp_waddr,
    output logic [BUS_WIDTH-1:0]    fp_wdata,
    output logic                    int_we,
    input  logic                    int_wr_ready,
    output logic [REG_ADDR-1:0]     int_waddr,
    output logic [BUS_WIDTH-1:0]    int_wdata,
    output logic [2**REG_ADDR-1:0]  fp_pending,
    output logic                    illegal_op,
    output logic [31:0]             wb_count
);
    typedef struct packed {
        route_e                route;
        logic [REG_ADDR-1:0]   rd;
        logic [BUS_WIDTH-1:0]  data;
    } wb_ent_t;

    localparam int EW = $bits(wb_ent_t);

    wb_ent_t                    in_ent, head, ent;
    logic                       accept, op_legal, push, pop, full, empty, head_vld;
    logic [$clog2(DEPTH):0]     fifo_count;
    logic [DEPTH-1:0]           ent_vld;
    logic [DEPTH-1:0][EW-1:0]   ent_data;

    assign accept   = in_valid && in_ready;
    assign op_legal = op_is_legal(32'(in_op));

    assign in_ent.route = op_route(32'(in_op));
    assign in_ent.rd    = in_rd;
    assign in_ent.data  = op_is_single(32'(in_op))
                        ? {{(BUS_WIDTH-32){1'b1}}, in_result[31:0]} : in_result;

    // INT writes to x0 are dropped here so they never occupy a slot.
    assign push = accept && op_legal && !(in_ent.route == ROUTE_INT && in_rd == '0);

    fpu_wb_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .wdata    (in_ent),
        .pop      (pop),
        .rdata    (head),
        .full     (full),
        .empty    (empty),
        .count    (fifo_count),
        .ent_vld  (ent_vld),
        .ent_data (ent_data)
    );

    assign in_ready  = !full;
    assign head_vld  = (fifo_count != '0);
    assign fp_we     = head_vld && head.route == ROUTE_FP;
    assign int_we    = head_vld && head.route == ROUTE_INT;
    assign fp_waddr  = fp_we  ? head.rd   : '0;
    assign fp_wdata  = fp_we  ? head.data : '0;
    assign int_waddr = int_we ? head.rd   : '0;
    assign int_wdata = int_we ? head.data : '0;
    assign pop       = !empty && (fp_we || (int_we && int_wr_ready));

    always_comb begin
        fp_pending = '0;
        ent        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent = ent_data[i];
            if (ent_vld[i] && ent.route == ROUTE_FP) fp_pending[ent.rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_op <= 1'b0;
            wb_count   <= '0;
        end else begin
            illegal_op <= accept && !op_legal;
            if (pop) wb_count <= wb_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fpu_writeback.sv
// Directed and randomized bench for fpu_writeback against a queue-based model.
module tb_fpu_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic [4:0]  in_op;
    logic [4:0]  in_rd;
    logic        fp_we;
    logic [4:0]  fp_waddr;
    logic [63:0] fp_wdata;
    logic        int_we;
    logic        int_wr_ready;
    logic [4:0]  int_waddr;
    logic [63:0] int_wdata;
    logic [31:0] fp_pending;
    logic        illegal_op;
    logic [31:0] wb_count;

    fpu_writeback dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_op(in_op), .in_rd(in_rd),
        .fp_we(fp_we), .fp_waddr(fp_waddr), .fp_wdata(fp_wdata),
        .int_we(int_we), .int_wr_ready(int_wr_ready), .int_waddr(int_waddr),
        .int_wdata(int_wdata), .fp_pending(fp_pending), .illegal_op(illegal_op),
        .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          fp;
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    ent_t        q[$];
    int unsigned exp_cnt;
    bit          exp_ill;
    int          checks = 0;
    int          passed = 0;
    int          fails  = 0;

    logic        o_in_ready, o_fp_we, o_int_we, o_ill;
    logic [4:0]  o_fp_waddr, o_int_waddr;
    logic [63:0] o_fp_wdata, o_int_wdata;
    logic [31:0] o_pend, o_wb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [31:0] pend;
        bit hv, hfp;
        pend = '0;
        foreach (q[i]) if (q[i].fp) pend[q[i].rd] = 1'b1;
        hv  = q.size() > 0;
        hfp = hv && q[0].fp;
        chk("in_ready",   in_ready,   64'(q.size() < 2));
        chk("fp_we",      fp_we,      64'(hfp));
        chk("int_we",     int_we,     64'(hv && !hfp));
        chk("fp_waddr",   fp_waddr,   hfp ? 64'(q[0].rd) : 64'd0);
        chk("fp_wdata",   fp_wdata,   hfp ? q[0].data : 64'd0);
        chk("int_waddr",  int_waddr,  (hv && !hfp) ? 64'(q[0].rd) : 64'd0);
        chk("int_wdata",  int_wdata,  (hv && !hfp) ? q[0].data : 64'd0);
        chk("fp_pending", fp_pending, 64'(pend));
        chk("illegal_op", illegal_op, 64'(exp_ill));
        chk("wb_count",   wb_count,   64'(exp_cnt));
    endtask

    // One clock: drive, compare at the falling edge, then advance the model.
    task automatic cyc(input bit v, input int op, input int rd, input logic [63:0] d, input bit rdy);
        bit acc, isfp;
        ent_t e;
        in_valid = v; in_op = 5'(op); in_rd = 5'(rd); in_result = d; int_wr_ready = rdy;
        @(negedge clk);
        o_in_ready = in_ready; o_fp_we = fp_we; o_int_we = int_we; o_ill = illegal_op;
        o_fp_waddr = fp_waddr; o_fp_wdata = fp_wdata; o_int_waddr = int_waddr;
        o_int_wdata = int_wdata; o_pend = fp_pending; o_wb = wb_count;
        check_model();
        @(posedge clk);
        acc = v && (q.size() < 2);
        if (q.size() > 0 && (q[0].fp || rdy)) begin
            void'(q.pop_front());
            exp_cnt++;
        end
        exp_ill = acc && op >= 14;
        if (acc && op < 14) begin
            isfp = !(op == 5 || op == 7);
            if (isfp || rd != 0) begin
                e.fp = isfp;
                e.rd = 5'(rd);
                e.data = (op >= 9) ? {32'hFFFF_FFFF, d[31:0]} : d;
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; int_wr_ready = 1'b0;
        #2 rst_n = 1'b0;
        q.delete(); exp_cnt = 0; exp_ill = 1'b0;
        #1 check_model();
        @(posedge clk); #1 check_model();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] wb_prev;
        int op, rd;
        rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_op = '0; in_rd = '0; int_wr_ready = 1'b0;
        q.delete(); exp_cnt = 0; exp_ill = 1'b0;
        #1 check_model();
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // single FP double
        cyc(1, 0, 3, 64'h4000_0000_0000_0000, 1);
        cyc(0, 0, 0, 0, 1);
        chk("t1_fp_we", o_fp_we, 1);
        chk("t1_waddr", o_fp_waddr, 3);
        chk("t1_wdata", o_fp_wdata, 64'h4000_0000_0000_0000);
        chk("t1_pend_set", o_pend[3], 1);
        cyc(0, 0, 0, 0, 1);
        chk("t1_pend_clr", o_pend[3], 0);
        chk("t1_wb", o_wb, 1);

        // single precision NaN-box
        cyc(1, 9, 4, 64'h0000_0000_3F80_0000, 1);
        cyc(0, 0, 0, 0, 1);
        chk("t2_nanbox", o_fp_wdata, 64'hFFFF_FFFF_3F80_0000);

        // stalled INT head, FIFO fills, then drains in order
        cyc(1, 5, 10, 64'h0123_4567_89AB_CDEF, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0);
            chk("t3_int_we", o_int_we, 1);
            chk("t3_int_addr", o_int_waddr, 10);
            chk("t3_int_data", o_int_wdata, 64'h0123_4567_89AB_CDEF);
        end
        cyc(1, 0, 2, 64'h1111, 0);
        cyc(1, 1, 5, 64'h5555, 0);
        chk("t3_full", o_in_ready, 0);
        cyc(1, 1, 5, 64'h5555, 1);
        chk("t3_int_go", o_int_we, 1);
        cyc(1, 1, 5, 64'h5555, 1);
        chk("t3_fp_rd2", o_fp_waddr, 2);
        chk("t3_ready_back", o_in_ready, 1);
        cyc(0, 0, 0, 0, 1);
        chk("t3_fp_rd5", o_fp_waddr, 5);

        // INT to x0 and illegal opcode
        cyc(0, 0, 0, 0, 1);
        wb_prev = o_wb;
        cyc(1, 7, 0, 64'hAA, 1);
        cyc(0, 0, 0, 0, 1);
        chk("t4_x0_no_we", o_int_we, 0);
        chk("t4_x0_wb", o_wb, 64'(wb_prev));
        cyc(1, 20, 6, 64'hBB, 1);
        cyc(0, 0, 0, 0, 1);
        chk("t4_ill_pulse", o_ill, 1);
        chk("t4_ill_no_we", o_fp_we, 0);
        cyc(0, 0, 0, 0, 1);
        chk("t4_ill_clear", o_ill, 0);

        // back-to-back FP throughput
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(1, i % 5, i + 1, {$urandom, $urandom}, 1);
            chk("t5_ready", o_in_ready, 1);
            if (i > 0) chk("t5_fp_we", o_fp_we, 1);
        end
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("t5_wb16", o_wb, 16);

        // reset with a stalled INT head and a full FIFO
        cyc(1, 5, 7, 64'h77, 0);
        cyc(1, 0, 8, 64'h88, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t6_full", o_in_ready, 0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1);
            chk("t6_no_fp", o_fp_we, 0);
            chk("t6_no_int", o_int_we, 0);
            chk("t6_wb0", o_wb, 0);
        end

        // randomized traffic
        for (int n = 0; n < 450; n++) begin
            if (n % 150 == 149) do_reset();
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 31)) : int'($urandom_range(0, 13));
            rd = int'($urandom_range(0, 31));
            cyc($urandom_range(0, 3) != 0, op, rd, {$urandom, $urandom}, $urandom_range(0, 2) != 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fpu_writeback.md
# fpu_writeback

Result/writeback stage directly downstream of the floating-point unit. It captures each FPU result with its opcode and destination register and buffers it in a 2-entry FIFO. It routes the result to the FP or integer register-file write port and NaN-boxes single-precision results bound for the FP file. It also exports a pending-destination mask for hazard detection and a committed-write counter.

## Interface
- BUS_WIDTH, 64: result/data width.
- OP_LEN, 5: FPU opcode width.
- REG_ADDR, 5: register index width.
- DEPTH, 2: result FIFO entries; power of two, ≥2.

- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  FPU result valid.
- in_ready  out  1  stage can accept; equals !full.
- in_result  in  BUS_WIDTH  FPU `out` value.
- in_op  in  OP_LEN  opcode that produced in_result.
- in_rd  in  REG_ADDR  destination register index.
- fp_we  out  1  FP register-file write enable; the FP file always accepts.
- fp_waddr  out  REG_ADDR  FP write index.
- fp_wdata  out  BUS_WIDTH  FP write data.
- int_we  out  1  integer register-file write request.
- int_wr_ready  in  1  integer port grant; the port is shared with ALU writeback.
- int_waddr  out  REG_ADDR  integer write index.
- int_wdata  out  BUS_WIDTH  integer write data.
- fp_pending  out  2^REG_ADDR  bit r set while any buffered entry targets FP register r.
- illegal_op  out  1  one-cycle pulse when an undefined opcode is accepted.
- wb_count  out  32  committed register-file writes; wraps.

## Operation
- Accept on in_valid && in_ready. Routing is decided at accept time and stored with the entry.
- Routing by opcode:
  - INT: 5 (fcvt.l.d), 7 (fmv.x.d). Data is passed unchanged.
  - FP, double/raw: 0–4, 6, 8. Data is passed unchanged.
  - FP, single: 9–13. Stored data = {32'hFFFF_FFFF, in_result[31:0]} (NaN-box); the incoming upper half is ignored.
  - Undefined opcodes 14–31: the entry is not stored, illegal_op pulses next cycle, and in_ready is unaffected.
  - INT route with in_rd == 0: the entry is not stored, and neither illegal_op nor wb_count changes.
- The FIFO head drives the outputs combinationally:
  - FP head: fp_we=1 for exactly one cycle, then pop.
  - INT head: int_we held with stable addr/data until int_wr_ready; pop on int_we && int_wr_ready.
  - Strict in-order drain. An FP entry behind a stalled INT head waits.
- fp_we and int_we are never both high.
- Push and pop in the same cycle: count unchanged. This is legal when full, but in_ready stays 0 that cycle because it is derived from count, not from pop.
- Pointers wrap modulo DEPTH.
- fp_pending is the OR over valid entries with FP route of the one-hot of rd.
- wb_count increments by 1 on each fp_we, and on each int_we && int_wr_ready.

## Timing
- Latency: accept in cycle N → write enable asserted in cycle N+1 when the FIFO was empty.
- fp_pending bit is set from cycle N+1 and clears in the cycle after the pop.
- Sustained FP throughput: one result per cycle.
- Reset values (asynchronous, immediate): count=0, pointers=0, fp_we=0, int_we=0, waddr/wdata=0, fp_pending=0, illegal_op=0, wb_count=0, in_ready=1.
- Reset mid-operation discards all buffered entries with no write issued. Outputs go to reset values while rst_n is low.

## Structure
- Shared package fpu_pkg holds:
  - opcode localparams (FOP_ADD_D … FOP_SQRT_S, values 0–13)
  - route enum {ROUTE_FP, ROUTE_INT}
  - the function op_route
  - the function op_is_single
- Sub-module fpu_wb_fifo: generic DEPTH×width synchronous FIFO with count, full, and empty. It also exposes a per-entry valid/payload view for the pending-mask OR.
- The top level holds the route/NaN-box logic, the drain control, and the counter.

## Test plan
- Single accept of op 0, rd=3, data 64'h4000_0000_0000_0000 → next cycle fp_we=1, fp_waddr=3, fp_wdata=64'h4000_0000_0000_0000; fp_pending[3]=1 that cycle and 0 after; wb_count=1.
- Op 9, rd=4, data 64'h0000_0000_3F80_0000 → fp_wdata=64'hFFFF_FFFF_3F80_0000.
- Op 5, rd=10 with int_wr_ready=0 for 3 cycles → int_we held high with constant addr/data. Then push op 0, rd=2, and op 1, rd=5: the FIFO fills and in_ready=0. Raise int_wr_ready → INT write, then FP writes to rd=2 and rd=5 in order; in_ready=1 again.
- Op 7, rd=0 → no write, wb_count unchanged. Op 20 → illegal_op pulses once, no write.
- Back-to-back FP results every cycle for 16 cycles → 16 consecutive fp_we, in_ready never drops, wb_count=16.
- Assert rst_n=0 with 2 entries buffered and the INT head stalled → all outputs are 0 immediately, in_ready=1, and no write occurs after release.
